// File: rtl/oled_pkg.sv
// Opcodes, parser state encoding and geometry defaults shared by the OLED SPI receiver.
package oled_pkg;

    localparam int unsigned COLS_DEFAULT  = 128;
    localparam int unsigned PAGES_DEFAULT = 8;

    localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OP_INVERT_OFF  = 8'hA6;
    localparam logic [7:0] OP_INVERT_ON   = 8'hA7;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_MEM_MODE    = 8'h20;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;

    typedef enum logic [1:0] {StIdle, StArg1, StArg2} parser_state_e;

    function automatic logic [1:0] arg_count(input logic [7:0] opcode);
        logic [1:0] n;
        case (opcode)
            OP_CONTRAST, OP_MEM_MODE, OP_CHARGE_PUMP, OP_MUX_RATIO,
            OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH: n = 2'd1;
            OP_COL_ADDR, OP_PAGE_ADDR:                           n = 2'd2;
            default:                                             n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_byte_deserializer.sv
// Synchronises the SPI pins, detects sclk rising edges and assembles MSB-first bytes.
module spi_byte_deserializer #(
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       cs,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [3:0] pins_raw;
    logic [3:0] pins;
    logic       sclk_s, sdin_s, cs_s, dc_s;
    logic       sclk_prev_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       rise;

    assign pins_raw = {sclk, sdin, cs, dc};

    if (SYNC_STAGES == 0) begin : g_direct
        assign pins = pins_raw;
    end else begin : g_sync
        // Idle pattern: sclk high, cs deasserted, so no edge or byte appears out of reset.
        localparam logic [3:0] PINS_IDLE = 4'b1010;
        logic [3:0] stage_q [SYNC_STAGES];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= PINS_IDLE;
            end else begin
                stage_q[0] <= pins_raw;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign pins = stage_q[SYNC_STAGES-1];
    end

    assign {sclk_s, sdin_s, cs_s, dc_s} = pins;
    assign rise = sclk_s & ~sclk_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            if (cs_s) begin
                bit_cnt_q <= '0;
            end else if (rise) begin
                shift_q   <= {shift_q[5:0], sdin_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // The eighth bit bypasses the shift register so the byte is presented in its own cycle.
    assign byte_valid = rise & ~cs_s & (bit_cnt_q == 3'd7);
    assign byte_data  = {shift_q, sdin_s};
    assign byte_dc    = dc_s;

endmodule

// File: rtl/oled_spi_receiver.sv
// SSD1306-style SPI panel model: command parser, config registers and framebuffer write port.
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned COLS        = COLS_DEFAULT,
    parameter int unsigned PAGES       = PAGES_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sclk_i,
    input  logic       sdin_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       oled_reset_i,
    output logic       fb_we_o,
    output logic [9:0] fb_addr_o,
    output logic [7:0] fb_data_o,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_byte_o,
    output logic       display_on_o,
    output logic [7:0] contrast_o,
    output logic       inverted_o,
    output logic       charge_pump_o
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(PAGES);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);

    logic          rst_n;
    logic          byte_valid, byte_dc, wr_en, cmd_en;
    logic [7:0]    byte_data;
    logic [9:0]    cur_addr;

    parser_state_e state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic          display_on_d, inverted_d, charge_pump_d;
    logic [7:0]    contrast_d;

    // The panel reset pin behaves exactly like the system reset.
    assign rst_n  = rst_n_i & oled_reset_i;
    assign wr_en  = byte_valid & byte_dc;
    assign cmd_en = byte_valid & ~byte_dc;
    assign cur_addr = 10'(32'(page_q) * COLS + 32'(col_q));

    spi_byte_deserializer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk        (clk_i),
        .rst_n      (rst_n),
        .sclk       (sclk_i),
        .sdin       (sdin_i),
        .cs         (cs_i),
        .dc         (dc_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wr_en) begin
            state_d = StIdle;
        end else if (cmd_en) begin
            unique case (state_q)
                StIdle:  state_d = (arg_count(byte_data) != 2'd0) ? StArg1 : StIdle;
                StArg1:  state_d = (arg_count(opcode_q) == 2'd2) ? StArg2 : StIdle;
                StArg2:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        opcode_d      = opcode_q;
        col_d         = col_q;
        col_start_d   = col_start_q;
        col_end_d     = col_end_q;
        page_d        = page_q;
        page_start_d  = page_start_q;
        page_end_d    = page_end_q;
        display_on_d  = display_on_o;
        inverted_d    = inverted_o;
        charge_pump_d = charge_pump_o;
        contrast_d    = contrast_o;
        if (wr_en) begin
            // Horizontal addressing; only equality with the window end wraps.
            if (col_q == col_end_q) begin
                col_d  = col_start_q;
                page_d = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (cmd_en) begin
            unique case (state_q)
                StIdle: begin
                    opcode_d = byte_data;
                    case (byte_data)
                        OP_DISPLAY_OFF: display_on_d = 1'b0;
                        OP_DISPLAY_ON:  display_on_d = 1'b1;
                        OP_INVERT_OFF:  inverted_d   = 1'b0;
                        OP_INVERT_ON:   inverted_d   = 1'b1;
                        default: ;
                    endcase
                end
                StArg1: begin
                    case (opcode_q)
                        OP_CONTRAST:    contrast_d    = byte_data;
                        OP_CHARGE_PUMP: charge_pump_d = byte_data[2];
                        OP_COL_ADDR: begin
                            col_start_d = byte_data[CW-1:0];
                            col_d       = byte_data[CW-1:0];
                        end
                        OP_PAGE_ADDR: begin
                            page_start_d = byte_data[PW-1:0];
                            page_d       = byte_data[PW-1:0];
                        end
                        default: ;
                    endcase
                end
                StArg2: begin
                    case (opcode_q)
                        OP_COL_ADDR:  col_end_d  = byte_data[CW-1:0];
                        OP_PAGE_ADDR: page_end_d = byte_data[PW-1:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            fb_we_o       <= 1'b0;
            fb_addr_o     <= '0;
            fb_data_o     <= '0;
            cmd_valid_o   <= 1'b0;
            cmd_byte_o    <= '0;
            display_on_o  <= 1'b0;
            contrast_o    <= 8'h7F;
            inverted_o    <= 1'b0;
            charge_pump_o <= 1'b0;
            opcode_q      <= '0;
            col_q         <= '0;
            col_start_q   <= '0;
            col_end_q     <= COL_MAX;
            page_q        <= '0;
            page_start_q  <= '0;
            page_end_q    <= PAGE_MAX;
        end else begin
            fb_we_o     <= wr_en;
            cmd_valid_o <= cmd_en;
            if (wr_en) begin
                fb_addr_o <= cur_addr;
                fb_data_o <= byte_data;
            end
            if (cmd_en) cmd_byte_o <= byte_data;
            display_on_o  <= display_on_d;
            contrast_o    <= contrast_d;
            inverted_o    <= inverted_d;
            charge_pump_o <= charge_pump_d;
            opcode_q      <= opcode_d;
            col_q         <= col_d;
            col_start_q   <= col_start_d;
            col_end_q     <= col_end_d;
            page_q        <= page_d;
            page_start_q  <= page_start_d;
            page_end_q    <= page_end_d;
        end
    end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench: one same-clock instance and one two-stage-synchroniser instance.
module tb_oled_spi_receiver;

    logic clk, rst_n, sclk, sdin, cs, dc, oled_reset, sel;
    logic cs_a, cs_b;

    logic       a_we, a_cv, a_don, a_inv, a_cp;
    logic [9:0] a_addr;
    logic [7:0] a_data, a_cbyte, a_con;
    logic       b_we, b_cv, b_don, b_inv, b_cp;
    logic [9:0] b_addr;
    logic [7:0] b_data, b_cbyte, b_con;

    int n_cmp = 0;
    int n_fail = 0;
    int a_cmd_cnt = 0, a_we_cnt = 0, b_cmd_cnt = 0, b_we_cnt = 0;
    logic [9:0] wr_addr[$];
    logic [7:0] wr_data[$];

    logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                                  8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                  8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    int exp_win [7] = '{266, 267, 268, 394, 395, 396, 266};

    assign cs_a = sel ? 1'b1 : cs;
    assign cs_b = sel ? cs : 1'b1;

    oled_spi_receiver #(.SYNC_STAGES(0)) dut_a (
        .clk_i (clk), .rst_n_i (rst_n), .sclk_i (sclk), .sdin_i (sdin), .cs_i (cs_a),
        .dc_i (dc), .oled_reset_i (oled_reset), .fb_we_o (a_we), .fb_addr_o (a_addr),
        .fb_data_o (a_data), .cmd_valid_o (a_cv), .cmd_byte_o (a_cbyte),
        .display_on_o (a_don), .contrast_o (a_con), .inverted_o (a_inv),
        .charge_pump_o (a_cp)
    );

    oled_spi_receiver #(.SYNC_STAGES(2)) dut_b (
        .clk_i (clk), .rst_n_i (rst_n), .sclk_i (sclk), .sdin_i (sdin), .cs_i (cs_b),
        .dc_i (dc), .oled_reset_i (oled_reset), .fb_we_o (b_we), .fb_addr_o (b_addr),
        .fb_data_o (b_data), .cmd_valid_o (b_cv), .cmd_byte_o (b_cbyte),
        .display_on_o (b_don), .contrast_o (b_con), .inverted_o (b_inv),
        .charge_pump_o (b_cp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_cv) a_cmd_cnt++;
        if (a_we) begin
            a_we_cnt++;
            wr_addr.push_back(a_addr);
            wr_data.push_back(a_data);
        end
        if (b_cv) b_cmd_cnt++;
        if (b_we) b_we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int n, input int half);
        @(negedge clk);
        cs = 1'b0;
        dc = d;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            sdin = b[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input int half);
        send_bits(b, d, 8, half);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_init(input int half);
        for (int i = 0; i < 23; i++) send_byte(init_seq[i], 1'b0, half);
    endtask

    initial begin
        int base_cmd, base_we, base_q, errs;
        rst_n = 1'b0; oled_reset = 1'b1; sclk = 1'b1; sdin = 1'b0; cs = 1'b1; dc = 1'b0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_we", 32'(a_we), 32'h0);
        check("rst_cv", 32'(a_cv), 32'h0);
        check("rst_addr", 32'(a_addr), 32'h0);
        check("rst_contrast", 32'(a_con), 32'h7F);
        check("rst_display", 32'(a_don), 32'h0);

        // Init stream at sclk period 2 clk
        base_cmd = a_cmd_cnt; base_we = a_we_cnt;
        send_init(1);
        settle();
        check("init_cmd_cnt", 32'(a_cmd_cnt - base_cmd), 32'd23);
        check("init_we_cnt", 32'(a_we_cnt - base_we), 32'd0);
        check("init_display", 32'(a_don), 32'h1);
        check("init_contrast", 32'(a_con), 32'h7F);
        check("init_cpump", 32'(a_cp), 32'h1);
        check("init_invert", 32'(a_inv), 32'h0);
        check("init_last_cmd", 32'(a_cbyte), 32'hAF);

        // 1025 data bytes over the full window
        base_q = wr_addr.size();
        for (int i = 0; i < 1025; i++) send_byte(8'(i), 1'b1, 1);
        settle();
        check("fill_we_cnt", 32'(wr_addr.size() - base_q), 32'd1025);
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (wr_addr[base_q + i] !== 10'(i) || wr_data[base_q + i] !== 8'(i)) errs++;
        end
        check("fill_seq_errs", 32'(errs), 32'd0);
        check("fill_addr_1023", 32'(wr_addr[base_q + 1023]), 32'd1023);
        check("fill_data_1023", 32'(wr_data[base_q + 1023]), 32'hFF);
        check("fill_wrap_addr", 32'(wr_addr[base_q + 1024]), 32'd0);
        check("fill_wrap_data", 32'(wr_data[base_q + 1024]), 32'h00);

        // Column window 10..12, page window 2..3
        send_byte(8'h21, 1'b0, 1); send_byte(8'h0A, 1'b0, 1); send_byte(8'h0C, 1'b0, 1);
        send_byte(8'h22, 1'b0, 1); send_byte(8'h02, 1'b0, 1); send_byte(8'h03, 1'b0, 1);
        base_q = wr_addr.size();
        for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i), 1'b1, 1);
        settle();
        check("win_we_cnt", 32'(wr_addr.size() - base_q), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("win_addr_%0d", i), 32'(wr_addr[base_q + i]), 32'(exp_win[i]));
            check($sformatf("win_data_%0d", i), 32'(wr_data[base_q + i]), 32'h10 + 32'(i));
        end

        // Partial byte aborted by cs, then full A7
        base_cmd = a_cmd_cnt; base_we = a_we_cnt;
        send_bits(8'hFF, 1'b0, 5, 1);
        cs_high();
        send_byte(8'hA7, 1'b0, 1);
        settle();
        check("cs_cmd_cnt", 32'(a_cmd_cnt - base_cmd), 32'd1);
        check("cs_we_cnt", 32'(a_we_cnt - base_we), 32'd0);
        check("cs_cmd_byte", 32'(a_cbyte), 32'hA7);
        check("cs_invert", 32'(a_inv), 32'h1);

        // Data byte abandons a pending contrast argument
        base_q = wr_addr.size();
        send_byte(8'h81, 1'b0, 1);
        send_byte(8'h55, 1'b1, 1);
        send_byte(8'hA6, 1'b0, 1);
        settle();
        check("abort_we_cnt", 32'(wr_addr.size() - base_q), 32'd1);
        check("abort_addr", 32'(wr_addr[base_q]), 32'd267);
        check("abort_data", 32'(wr_data[base_q]), 32'h55);
        check("abort_contrast", 32'(a_con), 32'h7F);
        check("abort_invert", 32'(a_inv), 32'h0);

        send_byte(8'h81, 1'b0, 1); send_byte(8'h33, 1'b0, 1);
        settle();
        check("contrast_set", 32'(a_con), 32'h33);

        // rst_n_i mid-byte
        send_bits(8'hF0, 1'b1, 4, 1);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst2_we", 32'(a_we), 32'h0);
        check("rst2_addr", 32'(a_addr), 32'h0);
        check("rst2_data", 32'(a_data), 32'h0);
        check("rst2_cmd_byte", 32'(a_cbyte), 32'h0);
        check("rst2_display", 32'(a_don), 32'h0);
        check("rst2_contrast", 32'(a_con), 32'h7F);
        check("rst2_cpump", 32'(a_cp), 32'h0);
        base_q = wr_addr.size();
        send_byte(8'h5A, 1'b1, 1);
        settle();
        check("rst2_wr_addr", 32'(wr_addr[base_q]), 32'd0);
        check("rst2_wr_data", 32'(wr_data[base_q]), 32'h5A);

        // Panel reset pin with a window set
        send_byte(8'h21, 1'b0, 1); send_byte(8'h05, 1'b0, 1); send_byte(8'h06, 1'b0, 1);
        send_byte(8'h22, 1'b0, 1); send_byte(8'h01, 1'b0, 1); send_byte(8'h01, 1'b0, 1);
        send_byte(8'hAF, 1'b0, 1); send_byte(8'hA7, 1'b0, 1);
        settle();
        check("prst_pre_display", 32'(a_don), 32'h1);
        @(negedge clk); oled_reset = 1'b0;
        repeat (2) @(negedge clk); oled_reset = 1'b1;
        @(negedge clk);
        check("prst_display", 32'(a_don), 32'h0);
        check("prst_invert", 32'(a_inv), 32'h0);
        check("prst_cmd_byte", 32'(a_cbyte), 32'h0);
        base_q = wr_addr.size();
        send_byte(8'hC3, 1'b1, 1);
        settle();
        check("prst_wr_addr", 32'(wr_addr[base_q]), 32'd0);
        check("prst_wr_data", 32'(wr_data[base_q]), 32'hC3);
        cs_high();

        // Init stream into the synchronised instance at sclk period 6 clk
        sel = 1'b1;
        base_cmd = b_cmd_cnt; base_we = b_we_cnt;
        send_init(3);
        settle();
        cs_high();
        check("sync_cmd_cnt", 32'(b_cmd_cnt - base_cmd), 32'd23);
        check("sync_we_cnt", 32'(b_we_cnt - base_we), 32'd0);
        check("sync_display", 32'(b_don), 32'h1);
        check("sync_contrast", 32'(b_con), 32'h7F);
        check("sync_cpump", 32'(b_cp), 32'h1);
        check("sync_invert", 32'(b_inv), 32'h0);
        check("sync_last_cmd", 32'(b_cbyte), 32'hAF);
        check("sync_addr_idle", 32'(b_addr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
